banked_regfile: RTL and testbench
=================================

BANKED_REGFILE -- requirements
Module: banked_regfile

Interface
REQ-001 Parameter WIDTH, default 8: data width of every register.
REQ-002 Parameter NREGS, default 4: architectural register count; power of two, at least 4.
REQ-003 Parameter NBANKS, default 2: number of banked copies, i.e. interrupt nesting depth plus one; at least 2.
REQ-004 Parameter BANK_BASE, default 2: registers at index BANK_BASE and above are banked; registers below it are global; BANK_BASE+2 <= NREGS.
REQ-005 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 nclr  in  1  asynchronous active-low reset.
REQ-008 ra_sel  in  log2(NREGS)  read port A select.
REQ-009 rb_sel  in  log2(NREGS)  read port B select.
REQ-010 wr_en  in  1  write strobe.
REQ-011 wr_sel  in  log2(NREGS)  write select.
REQ-012 wr_data  in  WIDTH  write data.
REQ-013 irq_enter  in  1  one-cycle interrupt entry pulse.
REQ-014 irq_exit  in  1  one-cycle interrupt return pulse.
REQ-015 ret_addr  in  2*WIDTH  return address captured on entry.
REQ-016 rd_a  out  WIDTH  port A data.
REQ-017 rd_b  out  WIDTH  port B data.
REQ-018 ret_out  out  2*WIDTH  current-bank {reg[BANK_BASE+1], reg[BANK_BASE]}.
REQ-019 level  out  log2(NBANKS), minimum 1  current bank index.
REQ-020 in_irq  out  1  high when level is nonzero.
REQ-021 ovf  out  1  sticky flag: entry attempted at the deepest level.
REQ-022 unf  out  1  sticky flag: exit attempted at level 0.

Function
REQ-023 Reads SHALL be combinational: global registers from the single copy, banked registers from the bank selected by the current level.
REQ-024 A write (wr_en high) SHALL update wr_sel at the next rising edge. A banked target is written in the bank at the pre-edge level.
REQ-025 There SHALL be no write-to-read bypass: a read in the same cycle as a write returns the old value.
REQ-026 The level counter SHALL have four cases per edge:
- Idle (no irq_enter, no irq_exit): level holds.
- Enter (irq_enter only, level < NBANKS-1): level increments; the new bank's reg[BANK_BASE] <= ret_addr[WIDTH-1:0] and reg[BANK_BASE+1] <= ret_addr[2*WIDTH-1:WIDTH].
- Exit (irq_exit only, level > 0): level decrements; bank contents are untouched.
- Chain (irq_enter and irq_exit together): level holds; the current bank's reg[BANK_BASE] and reg[BANK_BASE+1] load ret_addr (tail-chain).
REQ-027 Entry at level NBANKS-1 SHALL be ignored (level and registers unchanged) and SHALL set ovf.
REQ-028 Exit at level 0 SHALL be ignored and SHALL set unf.
REQ-029 Chain at level 0 SHALL behave as Chain, with neither flag set.
REQ-030 When a ret_addr load and a wr_en write hit the same physical register on the same edge, the ret_addr load SHALL win. A write to any other register SHALL complete normally.
REQ-031 ret_out, rd_a and rd_b SHALL reflect the new level in the cycle after a level change.
REQ-032 ovf and unf SHALL clear only on reset.
REQ-033 Banks other than the current and target bank SHALL never be modified.

Reset
REQ-034 While nclr is low, asynchronously: every register in every bank = 0, level = 0, ovf = 0, unf = 0; rd_a, rd_b and ret_out therefore read 0.
REQ-035 Reset asserted mid-operation SHALL abort any pending transition; nclr deasserts synchronously to clk in the system.

Verification (WIDTH=8, NREGS=4, NBANKS=2, BANK_BASE=2)
REQ-036 Write reg1=0x5A, then reg3=0x11 at level 0; read ra_sel=1, rb_sel=3 -> rd_a=0x5A, rd_b=0x11, ret_out=0x1100.
REQ-037 From REQ-036 state, irq_enter with ret_addr=0xBEEF:
- Next cycle: level=1, in_irq=1, ret_out=0xBEEF, reg1 still reads 0x5A.
- Then irq_exit: level=0, reg3 reads 0x11 again.
REQ-038 Overflow/underflow:
- At level 1, irq_enter -> level stays 1, ovf=1, ret_out unchanged.
- Reset, then irq_exit at level 0 -> unf=1, level 0.
REQ-039 Chain and collision at level 1: irq_enter, irq_exit and wr_en (wr_sel=2, 0x77) together with ret_addr=0x1234 -> level 1, ret_out=0x1234 (ret_addr beats the write).
REQ-040 Reset mid-interrupt: nclr pulsed low with no clock edge -> level=0, all reads 0, ovf=unf=0 immediately.
REQ-041 Same-cycle write then read: wr_sel=0, 0xA5, with ra_sel=0 -> rd_a shows the old value that cycle and 0xA5 the next cycle.

Source files
------------

// File: rtl/banked_regfile_if.sv
// rtl/banked_regfile_if.sv - register-file access, interrupt control and status bundle
interface banked_regfile_if #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 4,
    parameter int NBANKS = 2
);
    localparam int SW = $clog2(NREGS);
    localparam int LW = (NBANKS > 2) ? $clog2(NBANKS) : 1;

    logic [SW-1:0]      ra_sel;
    logic [SW-1:0]      rb_sel;
    logic               wr_en;
    logic [SW-1:0]      wr_sel;
    logic [WIDTH-1:0]   wr_data;
    logic               irq_enter;
    logic               irq_exit;
    logic [2*WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0]   rd_a;
    logic [WIDTH-1:0]   rd_b;
    logic [2*WIDTH-1:0] ret_out;
    logic [LW-1:0]      level;
    logic               in_irq;
    logic               ovf;
    logic               unf;

    modport master (
        output ra_sel, rb_sel, wr_en, wr_sel, wr_data, irq_enter, irq_exit, ret_addr,
        input  rd_a, rd_b, ret_out, level, in_irq, ovf, unf
    );

    modport slave (
        input  ra_sel, rb_sel, wr_en, wr_sel, wr_data, irq_enter, irq_exit, ret_addr,
        output rd_a, rd_b, ret_out, level, in_irq, ovf, unf
    );
endinterface

// File: rtl/banked_regfile.sv
// rtl/banked_regfile.sv - register file with per-interrupt-level banked upper registers
module banked_regfile #(
    parameter int WIDTH     = 8,
    parameter int NREGS     = 4,
    parameter int NBANKS    = 2,
    parameter int BANK_BASE = 2
) (
    input  logic              clk,
    input  logic              nclr,
    banked_regfile_if.slave   bus
);
    localparam int SW = $clog2(NREGS);
    localparam int LW = (NBANKS > 2) ? $clog2(NBANKS) : 1;

    localparam logic [SW-1:0] RET_LO   = SW'(BANK_BASE);
    localparam logic [SW-1:0] RET_HI   = SW'(BANK_BASE + 1);
    localparam logic [LW-1:0] TOP_LVL  = LW'(NBANKS - 1);
    localparam logic [LW-1:0] LVL_ZERO = '0;

    // Global registers live only in bank 0; their copies in other banks stay at reset value.
    logic [WIDTH-1:0] regs [NBANKS][NREGS];
    logic [LW-1:0]    level;
    logic             ovf;
    logic             unf;

    logic             enter_ok;
    logic             exit_ok;
    logic             chain;
    logic             load;
    logic [LW-1:0]    load_bank;
    logic [LW-1:0]    a_bank;
    logic [LW-1:0]    b_bank;
    logic [LW-1:0]    w_bank;

    function automatic logic [LW-1:0] bank_of(input logic [SW-1:0] sel, input logic [LW-1:0] lvl);
        return (sel >= RET_LO) ? lvl : LVL_ZERO;
    endfunction

    always_comb begin
        chain     = bus.irq_enter & bus.irq_exit;
        enter_ok  = bus.irq_enter & ~bus.irq_exit & (level != TOP_LVL);
        exit_ok   = bus.irq_exit & ~bus.irq_enter & (level != LVL_ZERO);
        load      = enter_ok | chain;
        load_bank = enter_ok ? level + LW'(1) : level;
        a_bank    = bank_of(bus.ra_sel, level);
        b_bank    = bank_of(bus.rb_sel, level);
        w_bank    = bank_of(bus.wr_sel, level);
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            for (int b = 0; b < NBANKS; b++) begin
                for (int r = 0; r < NREGS; r++) begin
                    regs[b][r] <= '0;
                end
            end
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                regs[w_bank][bus.wr_sel] <= bus.wr_data;
            end
            // Issued after the write so a colliding ret_addr load takes priority.
            if (load) begin
                regs[load_bank][RET_LO] <= bus.ret_addr[WIDTH-1:0];
                regs[load_bank][RET_HI] <= bus.ret_addr[2*WIDTH-1:WIDTH];
            end
            if (enter_ok) begin
                level <= level + LW'(1);
            end else if (exit_ok) begin
                level <= level - LW'(1);
            end
            if (bus.irq_enter && !bus.irq_exit && level == TOP_LVL) begin
                ovf <= 1'b1;
            end
            if (bus.irq_exit && !bus.irq_enter && level == LVL_ZERO) begin
                unf <= 1'b1;
            end
        end
    end

    assign bus.rd_a    = regs[a_bank][bus.ra_sel];
    assign bus.rd_b    = regs[b_bank][bus.rb_sel];
    assign bus.ret_out = {regs[level][RET_HI], regs[level][RET_LO]};
    assign bus.level   = level;
    assign bus.in_irq  = (level != LVL_ZERO);
    assign bus.ovf     = ovf;
    assign bus.unf     = unf;
endmodule

// File: tb/tb_banked_regfile.sv
// tb/tb_banked_regfile.sv - scoreboard bench for banked_regfile
module tb_banked_regfile;
    localparam int WIDTH = 8;

    typedef enum int {S_RD_A, S_RD_B, S_RET, S_LEVEL, S_IN_IRQ, S_OVF, S_UNF} sig_t;

    typedef struct {
        string       name;
        sig_t        sig;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic nclr;
    int   applied;
    int   miscompares;
    exp_t sb[$];
    event sample_ev;

    banked_regfile_if #(.WIDTH(8), .NREGS(4), .NBANKS(2)) bus ();

    banked_regfile #(.WIDTH(8), .NREGS(4), .NBANKS(2), .BANK_BASE(2)) dut (
        .clk  (clk),
        .nclr (nclr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input sig_t s);
        case (s)
            S_RD_A:   return 32'(bus.rd_a);
            S_RD_B:   return 32'(bus.rd_b);
            S_RET:    return 32'(bus.ret_out);
            S_LEVEL:  return 32'(bus.level);
            S_IN_IRQ: return 32'(bus.in_irq);
            S_OVF:    return 32'(bus.ovf);
            default:  return 32'(bus.unf);
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = actual(e.sig);
                applied++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input sig_t s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sig  = s;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        -> sample_ev;
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.irq_enter = 1'b0;
        bus.irq_exit  = 1'b0;
    endtask

    initial begin : stimulus
        applied     = 0;
        miscompares = 0;
        nclr          = 1'b0;
        bus.ra_sel    = '0;
        bus.rb_sel    = '0;
        bus.wr_sel    = '0;
        bus.wr_data   = '0;
        bus.ret_addr  = '0;
        idle_inputs();
        #12;
        expect_val("reset_level", S_LEVEL, 0);
        expect_val("reset_in_irq", S_IN_IRQ, 0);
        expect_val("reset_ovf", S_OVF, 0);
        expect_val("reset_unf", S_UNF, 0);
        expect_val("reset_rd_a", S_RD_A, 0);
        expect_val("reset_ret", S_RET, 0);
        -> sample_ev;
        @(negedge clk);
        nclr = 1'b1;

        // Level-0 writes and combinational reads
        edge_step();
        bus.wr_en = 1'b1; bus.wr_sel = 2'd1; bus.wr_data = 8'h5A;
        edge_step();
        bus.wr_sel = 2'd3; bus.wr_data = 8'h11;
        edge_step();
        idle_inputs();
        bus.ra_sel = 2'd1; bus.rb_sel = 2'd3;
        expect_val("l0_rd_a", S_RD_A, 32'h5A);
        expect_val("l0_rd_b", S_RD_B, 32'h11);
        expect_val("l0_ret", S_RET, 32'h1100);
        expect_val("l0_level", S_LEVEL, 0);
        sample();

        // Interrupt entry
        bus.irq_enter = 1'b1; bus.ret_addr = 16'hBEEF;
        edge_step();
        idle_inputs();
        expect_val("enter_level", S_LEVEL, 1);
        expect_val("enter_in_irq", S_IN_IRQ, 1);
        expect_val("enter_ret", S_RET, 32'hBEEF);
        expect_val("enter_global_rd_a", S_RD_A, 32'h5A);
        expect_val("enter_banked_rd_b", S_RD_B, 32'hBE);
        sample();

        // Interrupt exit restores bank 0 view
        bus.irq_exit = 1'b1;
        edge_step();
        idle_inputs();
        expect_val("exit_level", S_LEVEL, 0);
        expect_val("exit_rd_b", S_RD_B, 32'h11);
        expect_val("exit_ret", S_RET, 32'h1100);
        expect_val("exit_in_irq", S_IN_IRQ, 0);
        sample();

        // Re-enter, then overflow attempt at the deepest level
        bus.irq_enter = 1'b1; bus.ret_addr = 16'hCAFE;
        edge_step();
        bus.ret_addr = 16'h9999;
        edge_step();
        idle_inputs();
        expect_val("ovf_level", S_LEVEL, 1);
        expect_val("ovf_flag", S_OVF, 1);
        expect_val("ovf_ret_kept", S_RET, 32'hCAFE);
        expect_val("ovf_unf_clear", S_UNF, 0);
        sample();

        // Chain with colliding write at level 1: ret_addr wins
        bus.irq_enter = 1'b1; bus.irq_exit = 1'b1; bus.ret_addr = 16'h1234;
        bus.wr_en = 1'b1; bus.wr_sel = 2'd2; bus.wr_data = 8'h77;
        edge_step();
        idle_inputs();
        expect_val("chain_level", S_LEVEL, 1);
        expect_val("chain_ret", S_RET, 32'h1234);
        expect_val("chain_ovf_sticky", S_OVF, 1);
        sample();

        // Chain with a non-colliding write to a global register
        bus.irq_enter = 1'b1; bus.irq_exit = 1'b1; bus.ret_addr = 16'h5678;
        bus.wr_en = 1'b1; bus.wr_sel = 2'd1; bus.wr_data = 8'h3C;
        edge_step();
        idle_inputs();
        expect_val("chain2_ret", S_RET, 32'h5678);
        expect_val("chain2_write_rd_a", S_RD_A, 32'h3C);
        sample();

        // Exit: bank 0 untouched by level-1 activity
        bus.irq_exit = 1'b1;
        edge_step();
        idle_inputs();
        expect_val("exit2_level", S_LEVEL, 0);
        expect_val("exit2_ret_bank0", S_RET, 32'h1100);
        sample();

        // Chain at level 0: no flag change
        bus.irq_enter = 1'b1; bus.irq_exit = 1'b1; bus.ret_addr = 16'hABCD;
        edge_step();
        idle_inputs();
        expect_val("chain0_level", S_LEVEL, 0);
        expect_val("chain0_ret", S_RET, 32'hABCD);
        expect_val("chain0_unf", S_UNF, 0);
        expect_val("chain0_ovf_sticky", S_OVF, 1);
        sample();

        // Plain write to banked reg2 at level 0
        bus.wr_en = 1'b1; bus.wr_sel = 2'd2; bus.wr_data = 8'h77;
        edge_step();
        idle_inputs();
        expect_val("wr_reg2_ret", S_RET, 32'hAB77);
        sample();

        // Reset asserted mid-interrupt without a clock edge
        bus.irq_enter = 1'b1; bus.ret_addr = 16'h4242;
        edge_step();
        idle_inputs();
        expect_val("pre_rst_level", S_LEVEL, 1);
        sample();
        #1 nclr = 1'b0;
        #1;
        expect_val("arst_level", S_LEVEL, 0);
        expect_val("arst_in_irq", S_IN_IRQ, 0);
        expect_val("arst_ovf", S_OVF, 0);
        expect_val("arst_unf", S_UNF, 0);
        expect_val("arst_rd_a", S_RD_A, 0);
        expect_val("arst_rd_b", S_RD_B, 0);
        expect_val("arst_ret", S_RET, 0);
        -> sample_ev;
        @(negedge clk);
        nclr = 1'b1;

        // Underflow at level 0
        bus.irq_exit = 1'b1;
        edge_step();
        idle_inputs();
        expect_val("unf_flag", S_UNF, 1);
        expect_val("unf_level", S_LEVEL, 0);
        expect_val("unf_ovf_clear", S_OVF, 0);
        sample();

        // Same-cycle write then read: no bypass
        bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_data = 8'h33;
        edge_step();
        bus.wr_data = 8'hA5; bus.ra_sel = 2'd0;
        expect_val("nobypass_old", S_RD_A, 32'h33);
        sample();
        edge_step();
        idle_inputs();
        expect_val("nobypass_new", S_RD_A, 32'hA5);
        sample();

        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
